// File: rtl/gray_counter.sv
// Up/down Gray counter built on one binary register; wraps or saturates at the range ends.
// Latency: 1 clock from any input edge to gray_out/bin_out/term, all registered together.
// Backpressure: none; en gates counting, load overrides en, and en=0 holds.
module gray_counter #(
    parameter int WIDTH    = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_gray,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] bin_out,
    output logic             term
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;

    logic [WIDTH-1:0] bin_nxt;
    logic             term_nxt;
    logic             at_limit;

    function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b            = '0;
        b[WIDTH-1]   = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    always_comb begin
        bin_nxt  = bin_out;
        term_nxt = 1'b0;
        at_limit = up ? (bin_out == MAX_VAL) : (bin_out == '0);
        if (load) begin
            // A load never flags a terminal event, even when it lands on 0 or max.
            bin_nxt = gray_to_bin(load_gray);
        end else if (en) begin
            if (at_limit) begin
                term_nxt = 1'b1;
                if (!SATURATE) begin
                    bin_nxt = up ? '0 : MAX_VAL;
                end
            end else begin
                bin_nxt = up ? bin_out + 1'b1 : bin_out - 1'b1;
            end
        end
    end

    // gray_out is registered from the same next-state as bin_out, so the two never skew.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_out  <= '0;
            gray_out <= '0;
            term     <= 1'b0;
        end else begin
            bin_out  <= bin_nxt;
            gray_out <= bin_nxt ^ (bin_nxt >> 1);
            term     <= term_nxt;
        end
    end

endmodule

// File: tb/tb_gray_counter.sv
// Drives wrap-4, saturate-4 and wrap-8 counters from shared controls; a queued
// integer model supplies every expected gray/bin/term value.
module tb_gray_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en, up, load;
    logic [3:0] lg4;
    logic [7:0] lg8;
    logic [3:0] g4, b4, gs, bs;
    logic [7:0] g8, b8;
    logic       t4, ts, t8;

    int vectors     = 0;
    int miscompares = 0;
    int m4, ms, m8;

    typedef struct {
        int b4; bit t4;
        int bs; bit ts;
        int b8; bit t8;
    } exp_t;
    exp_t sb[$];

    logic [3:0] gtab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                              4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    always #5 clk = ~clk;

    gray_counter #(.WIDTH(4), .SATURATE(1'b0)) u_w4 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .load_gray(lg4), .gray_out(g4), .bin_out(b4), .term(t4));
    gray_counter #(.WIDTH(4), .SATURATE(1'b1)) u_s4 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .load_gray(lg4), .gray_out(gs), .bin_out(bs), .term(ts));
    gray_counter #(.WIDTH(8), .SATURATE(1'b0)) u_w8 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .load_gray(lg8), .gray_out(g8), .bin_out(b8), .term(t8));

    function automatic logic [31:0] to_gray(input int b);
        return 32'(b ^ (b >> 1));
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic int g2b(input int g, input int w);
        int gm = g & ((1 << w) - 1);
        int b  = 0;
        for (int i = 0; i < w; i++) b[i] = ^(gm >> i);
        return b;
    endfunction

    task automatic mdl(input int w, input bit sat, input int b_in, input bit e, input bit u,
                       input bit l, input int lg, output int b_out, output bit t);
        int maxv = (1 << w) - 1;
        t     = 1'b0;
        b_out = b_in;
        if (l) begin
            b_out = g2b(lg, w);
        end else if (e && u) begin
            if (b_in == maxv) begin t = 1'b1; b_out = sat ? maxv : 0; end
            else b_out = b_in + 1;
        end else if (e) begin
            if (b_in == 0) begin t = 1'b1; b_out = sat ? 0 : maxv; end
            else b_out = b_in - 1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_w4g"}, 32'(g4), 0); check({tag, "_w4b"}, 32'(b4), 0); check({tag, "_w4t"}, 32'(t4), 0);
        check({tag, "_s4g"}, 32'(gs), 0); check({tag, "_s4b"}, 32'(bs), 0); check({tag, "_s4t"}, 32'(ts), 0);
        check({tag, "_w8g"}, 32'(g8), 0); check({tag, "_w8b"}, 32'(b8), 0); check({tag, "_w8t"}, 32'(t8), 0);
    endtask

    task automatic step(input bit e, input bit u, input bit l, input logic [7:0] lg);
        exp_t       x;
        int         n4, ns, n8;
        bit         ta, tb, tc;
        logic [3:0] pg4, pgs;
        logic [7:0] pg8;
        pg4 = g4; pgs = gs; pg8 = g8;
        @(negedge clk);
        en = e; up = u; load = l; lg4 = lg[3:0]; lg8 = lg;
        mdl(4, 1'b0, m4, e, u, l, int'(lg[3:0]), n4, ta);
        mdl(4, 1'b1, ms, e, u, l, int'(lg[3:0]), ns, tb);
        mdl(8, 1'b0, m8, e, u, l, int'(lg), n8, tc);
        sb.push_back('{n4, ta, ns, tb, n8, tc});
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check("w4_gray", 32'(g4), to_gray(x.b4)); check("w4_bin", 32'(b4), 32'(x.b4)); check("w4_term", 32'(t4), 32'(x.t4));
        check("s4_gray", 32'(gs), to_gray(x.bs)); check("s4_bin", 32'(bs), 32'(x.bs)); check("s4_term", 32'(ts), 32'(x.ts));
        check("w8_gray", 32'(g8), to_gray(x.b8)); check("w8_bin", 32'(b8), 32'(x.b8)); check("w8_term", 32'(t8), 32'(x.t8));
        if (!l && e) begin
            if (x.b4 != m4) check("w4_onebit", 32'($countones(g4 ^ pg4)), 1);
            if (x.bs != ms) check("s4_onebit", 32'($countones(gs ^ pgs)), 1);
            if (x.b8 != m8) check("w8_onebit", 32'($countones(g8 ^ pg8)), 1);
        end
        m4 = x.b4; ms = x.bs; m8 = x.b8;
    endtask

    // Reset is asserted between edges and checked before any edge arrives.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero(tag);
        @(negedge clk);
        en = 1'b0; load = 1'b0; up = 1'b1;
        rst_n = 1'b1;
        m4 = 0; ms = 0; m8 = 0;
    endtask

    initial begin
        en = 1'b0; up = 1'b1; load = 1'b0; lg4 = '0; lg8 = '0;
        m4 = 0; ms = 0; m8 = 0;
        rst_n = 1'b0;
        #2 check_all_zero("por");
        @(negedge clk) rst_n = 1'b1;

        // Full up-count cycle through wrap.
        for (int i = 0; i < 17; i++) begin
            step(1'b1, 1'b1, 1'b0, 8'h00);
            check("up_gray_tab", 32'(g4), 32'(gtab[(i + 1) % 16]));
            check("up_bin_seq", 32'(b4), 32'((i + 1) % 16));
            check("up_term", 32'(t4), 32'(i == 15));
        end
        step(1'b0, 1'b1, 1'b0, 8'h00);
        check("hold_term", 32'(t4), 0);

        // Load wins over en; loading max never raises term.
        step(1'b1, 1'b1, 1'b1, 8'h0C);
        check("ld_bin", 32'(b4), 32'h8); check("ld_gray", 32'(g4), 32'hC); check("ld_term", 32'(t4), 0);
        step(1'b1, 1'b1, 1'b1, 8'h08);
        check("ldmax_bin", 32'(bs), 32'hF); check("ldmax_term", 32'(ts), 0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 8'h00);
            check("sat_gray", 32'(gs), 32'h8); check("sat_bin", 32'(bs), 32'hF); check("sat_term", 32'(ts), 1);
        end
        step(1'b1, 1'b1, 1'b1, 8'h00);
        check("ldzero_term", 32'(ts), 0);

        // Decrement from reset wraps to max.
        do_reset("rst_a");
        step(1'b1, 1'b0, 1'b0, 8'h00);
        check("dn_bin", 32'(b4), 32'hF); check("dn_gray", 32'(g4), 32'h8); check("dn_term", 32'(t4), 1);
        check("dn_sat_bin", 32'(bs), 0); check("dn_sat_term", 32'(ts), 1);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check("dn_term_clr", 32'(t4), 0);

        // Mid-count reset discards the count.
        do_reset("rst_b");
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 8'h00);
        check("pre_rst_bin", 32'(b4), 6);
        do_reset("rst_mid");
        #1 check("post_rst_bin", 32'(b4), 0);
        step(1'b1, 1'b1, 1'b0, 8'h00);
        check("restart_1", 32'(b4), 1);
        step(1'b1, 1'b1, 1'b0, 8'h00);
        check("restart_2", 32'(b4), 2);

        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 15) == 0), 8'($urandom_range(0, 255)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
